baccarat_datapath: RTL and testbench



---
 rtl/baccarat_datapath.sv | 151 +++++++++++++++
 tb/tb_baccarat_datapath.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/baccarat_datapath.sv
// Baccarat deal datapath: takes one-hot slot load commands from the game FSM and draws
// cards from a free-running rank generator into six hand registers. It computes both hand
// scores, the third-card draw decisions and the outcome, and flags illegal commands.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   deal_player_card[2:0]    one-hot load of player slot 1/2/3
//   deal_dealer_card[2:0]    one-hot load of dealer slot 1/2/3
//   clear_hands              synchronous clear of all hands and cmd_error (beats loads)
//   pcard1..3, dcard1..3     card ranks, 0 = empty, 1..13 = A..K
//   pscore, dscore           hand scores 0..9 over all loaded cards
//   player_draw, dealer_draw third-card decisions
//   result_valid             hand complete; player_win / dealer_win valid (both low = tie)
//   cmd_error                sticky illegal-command flag
module baccarat_datapath #(
    parameter int unsigned NUM_RANKS = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] deal_player_card,
    input  logic [2:0] deal_dealer_card,
    input  logic       clear_hands,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic       player_draw,
    output logic       dealer_draw,
    output logic       result_valid,
    output logic       player_win,
    output logic       dealer_win,
    output logic       cmd_error
);

    // Slots 0..2 are player cards 1..3, slots 3..5 are dealer cards 1..3.
    logic [5:0][3:0] card_q, card_d;
    logic [3:0]      gen_q, gen_d;
    logic            err_q, err_d;

    logic [5:0] cmd, empty, prev_empty, bad;
    logic       stage, illegal, natural, dealer_resolved;
    logic [3:0] p_two, d_two;
    logic [4:0] p3;

    function automatic logic [4:0] card_val(input logic [3:0] rank);
        return (rank >= 4'd1 && rank <= 4'd9) ? {1'b0, rank} : 5'd0;
    endfunction

    // Sums never exceed 27, so two subtraction steps cover the modulo.
    function automatic logic [3:0] mod10(input logic [4:0] s);
        logic [4:0] r;
        if (s >= 5'd20)      r = s - 5'd20;
        else if (s >= 5'd10) r = s - 5'd10;
        else                 r = s;
        return r[3:0];
    endfunction

    assign cmd = {deal_dealer_card, deal_player_card};

    always_comb begin
        for (int i = 0; i < 6; i++) empty[i] = (card_q[i] == 4'd0);
    end

    assign prev_empty = {empty[4], empty[3], 1'b0, empty[1], empty[0], 1'b0};
    assign stage      = ~empty[0] & ~empty[1] & ~empty[3] & ~empty[4];
    // Per-slot faults: occupied, predecessor empty, or third card before the two-card stage.
    assign bad        = cmd & (~empty | prev_empty | (6'b100100 & {6{~stage}}));
    assign illegal    = !$onehot(cmd) || (|bad);

    assign gen_d = (gen_q == 4'(NUM_RANKS)) ? 4'd1 : gen_q + 4'd1;

    always_comb begin
        card_d = card_q;
        err_d  = err_q;
        if (clear_hands) begin
            card_d = '0;
            err_d  = 1'b0;
        end else if (cmd != 6'd0) begin
            if (illegal) begin
                err_d = 1'b1;
            end else begin
                for (int i = 0; i < 6; i++) begin
                    if (cmd[i]) card_d[i] = gen_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            card_q <= '0;
            gen_q  <= 4'd1;
            err_q  <= 1'b0;
        end else begin
            card_q <= card_d;
            gen_q  <= gen_d;
            err_q  <= err_d;
        end
    end

    assign pscore = mod10(card_val(card_q[0]) + card_val(card_q[1]) + card_val(card_q[2]));
    assign dscore = mod10(card_val(card_q[3]) + card_val(card_q[4]) + card_val(card_q[5]));
    assign p_two  = mod10(card_val(card_q[0]) + card_val(card_q[1]));
    assign d_two  = mod10(card_val(card_q[3]) + card_val(card_q[4]));
    assign p3     = card_val(card_q[2]);

    assign natural     = stage && (p_two >= 4'd8 || d_two >= 4'd8);
    assign player_draw = stage && !natural && (p_two <= 4'd5);

    always_comb begin
        dealer_resolved = 1'b0;
        dealer_draw     = 1'b0;
        if (stage) begin
            if (natural) begin
                dealer_resolved = 1'b1;
            end else if (!player_draw) begin
                dealer_resolved = 1'b1;
                dealer_draw     = (d_two <= 4'd5);
            end else if (!empty[2]) begin
                // Player drew: decision depends on the player's third card value.
                dealer_resolved = 1'b1;
                case (d_two)
                    4'd0, 4'd1, 4'd2: dealer_draw = 1'b1;
                    4'd3:    dealer_draw = (p3 != 5'd8);
                    4'd4:    dealer_draw = (p3 >= 5'd2 && p3 <= 5'd7);
                    4'd5:    dealer_draw = (p3 >= 5'd4 && p3 <= 5'd7);
                    4'd6:    dealer_draw = (p3 >= 5'd6 && p3 <= 5'd7);
                    default: dealer_draw = 1'b0;
                endcase
            end
        end
    end

    assign result_valid = stage && (!player_draw || !empty[2]) && dealer_resolved &&
                          (!dealer_draw || !empty[5]);
    assign player_win   = result_valid && (pscore > dscore);
    assign dealer_win   = result_valid && (dscore > pscore);

    assign pcard1    = card_q[0];
    assign pcard2    = card_q[1];
    assign pcard3    = card_q[2];
    assign dcard1    = card_q[3];
    assign dcard2    = card_q[4];
    assign dcard3    = card_q[5];
    assign cmd_error = err_q;

endmodule

// File: tb/tb_baccarat_datapath.sv
// Bench for baccarat_datapath: a reference model predicts the state after each edge, the
// prediction is queued when stimulus is driven and popped/compared after the edge.
module tb_baccarat_datapath;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] deal_player_card = 3'd0;
    logic [2:0] deal_dealer_card = 3'd0;
    logic       clear_hands = 1'b0;
    logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore;
    logic       player_draw, dealer_draw, result_valid, player_win, dealer_win, cmd_error;

    always #5 clk = ~clk;

    baccarat_datapath #(.NUM_RANKS(13)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .deal_player_card (deal_player_card),
        .deal_dealer_card (deal_dealer_card),
        .clear_hands      (clear_hands),
        .pcard1           (pcard1),
        .pcard2           (pcard2),
        .pcard3           (pcard3),
        .dcard1           (dcard1),
        .dcard2           (dcard2),
        .dcard3           (dcard3),
        .pscore           (pscore),
        .dscore           (dscore),
        .player_draw      (player_draw),
        .dealer_draw      (dealer_draw),
        .result_valid     (result_valid),
        .player_win       (player_win),
        .dealer_win       (dealer_win),
        .cmd_error        (cmd_error)
    );

    typedef struct packed {
        logic [5:0][3:0] cards;
        logic [3:0]      ps;
        logic [3:0]      ds;
        logic            pd;
        logic            dd;
        logic            rv;
        logic            pw;
        logic            dw;
        logic            err;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    string cur_tag = "";

    // Reference model state.
    logic [5:0][3:0] m_cards = '0;
    logic            m_err = 1'b0;
    int              m_gen = 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d, expected %0d", cur_tag, tag, obs, exp);
        end
    endtask

    function automatic int val(input int rank);
        return (rank >= 1 && rank <= 9) ? rank : 0;
    endfunction

    function automatic exp_t predict(input logic [5:0][3:0] c, input logic err);
        exp_t e;
        int   pt, dt, p3v;
        bit   stg, nat, res;
        e       = '0;
        e.cards = c;
        e.err   = err;
        e.ps    = 4'((val(int'(c[0])) + val(int'(c[1])) + val(int'(c[2]))) % 10);
        e.ds    = 4'((val(int'(c[3])) + val(int'(c[4])) + val(int'(c[5]))) % 10);
        pt      = (val(int'(c[0])) + val(int'(c[1]))) % 10;
        dt      = (val(int'(c[3])) + val(int'(c[4]))) % 10;
        stg     = (c[0] != 0) && (c[1] != 0) && (c[3] != 0) && (c[4] != 0);
        nat     = stg && (pt >= 8 || dt >= 8);
        e.pd    = stg && !nat && pt <= 5;
        res     = 1'b0;
        if (!stg) res = 1'b0;
        else if (nat) res = 1'b1;
        else if (!e.pd) begin
            res  = 1'b1;
            e.dd = (dt <= 5);
        end else if (c[2] != 0) begin
            res = 1'b1;
            p3v = val(int'(c[2]));
            if (dt <= 2)      e.dd = 1'b1;
            else if (dt == 3) e.dd = (p3v != 8);
            else if (dt == 4) e.dd = (p3v >= 2 && p3v <= 7);
            else if (dt == 5) e.dd = (p3v >= 4 && p3v <= 7);
            else if (dt == 6) e.dd = (p3v == 6 || p3v == 7);
            else              e.dd = 1'b0;
        end
        e.rv = stg && (!e.pd || c[2] != 0) && res && (!e.dd || c[5] != 0);
        e.pw = e.rv && (e.ps > e.ds);
        e.dw = e.rv && (e.ds > e.ps);
        return e;
    endfunction

    // Advance the model by one clock edge with the given inputs.
    function automatic void model_step(input logic [2:0] pc, input logic [2:0] dc,
                                       input logic clr);
        logic [5:0] cmd;
        int         ones, slot, pos;
        bit         stg, faulty;
        cmd = {dc, pc};
        if (clr) begin
            m_cards = '0;
            m_err   = 1'b0;
        end else if (cmd != 0) begin
            ones = 0;
            slot = 0;
            for (int i = 0; i < 6; i++) if (cmd[i]) begin ones++; slot = i; end
            stg = (m_cards[0] != 0) && (m_cards[1] != 0) && (m_cards[3] != 0) &&
                  (m_cards[4] != 0);
            pos    = slot % 3;
            faulty = (ones != 1) || (m_cards[slot] != 0) ||
                     (pos > 0 && m_cards[slot-1] == 0) || (pos == 2 && !stg);
            if (faulty) m_err = 1'b1;
            else        m_cards[slot] = 4'(m_gen);
        end
        m_gen = (m_gen == 13) ? 1 : m_gen + 1;
    endfunction

    task automatic compare_outputs(input exp_t e);
        check_eq("pcard1", pcard1, e.cards[0]);
        check_eq("pcard2", pcard2, e.cards[1]);
        check_eq("pcard3", pcard3, e.cards[2]);
        check_eq("dcard1", dcard1, e.cards[3]);
        check_eq("dcard2", dcard2, e.cards[4]);
        check_eq("dcard3", dcard3, e.cards[5]);
        check_eq("pscore", pscore, e.ps);
        check_eq("dscore", dscore, e.ds);
        check_eq("player_draw", player_draw, e.pd);
        check_eq("dealer_draw", dealer_draw, e.dd);
        check_eq("result_valid", result_valid, e.rv);
        check_eq("player_win", player_win, e.pw);
        check_eq("dealer_win", dealer_win, e.dw);
        check_eq("cmd_error", cmd_error, e.err);
    endtask

    task automatic cycle(input string tag, input logic [2:0] pc, input logic [2:0] dc,
                         input logic clr);
        @(negedge clk);
        deal_player_card = pc;
        deal_dealer_card = dc;
        clear_hands      = clr;
        model_step(pc, dc, clr);
        exp_q.push_back(predict(m_cards, m_err));
        @(posedge clk);
        #1;
        deal_player_card = 3'd0;
        deal_dealer_card = 3'd0;
        clear_hands      = 1'b0;
        cur_tag          = tag;
        if (exp_q.size() == 0) check_eq("queue_empty", 1, 0);
        else                   compare_outputs(exp_q.pop_front());
    endtask

    // Assert reset between edges, check the asynchronous clear, release after an edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        m_cards = '0;
        m_err   = 1'b0;
        m_gen   = 1;
        cur_tag = tag;
        compare_outputs(predict(m_cards, m_err));
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset("reset");

        // Player draws a 5 and wins 9 to 6.
        cycle("t1_p1", 3'b001, 3'b000, 1'b0);
        cycle("t1_d1", 3'b000, 3'b001, 1'b0);
        cycle("t1_p2", 3'b010, 3'b000, 1'b0);
        cycle("t1_d2", 3'b000, 3'b010, 1'b0);
        cycle("t1_p3", 3'b100, 3'b000, 1'b0);

        // Naturals: cards 8,9,10,11.
        do_reset("reset2");
        for (int i = 0; i < 7; i++) cycle("t2_idle", 3'b000, 3'b000, 1'b0);
        cycle("t2_p1", 3'b001, 3'b000, 1'b0);
        cycle("t2_d1", 3'b000, 3'b001, 1'b0);
        cycle("t2_p2", 3'b010, 3'b000, 1'b0);
        cycle("t2_d2", 3'b000, 3'b010, 1'b0);
        cycle("t2_d3", 3'b000, 3'b100, 1'b0);

        // Multiple bits set, then clear.
        cycle("t3_clr", 3'b000, 3'b000, 1'b1);
        cycle("t3_multi", 3'b001, 3'b001, 1'b0);
        cycle("t3_clr2", 3'b000, 3'b000, 1'b1);

        // Order errors and occupied-slot reload.
        cycle("t4_p2first", 3'b010, 3'b000, 1'b0);
        cycle("t4_clr", 3'b000, 3'b000, 1'b1);
        cycle("t4_p1", 3'b001, 3'b000, 1'b0);
        cycle("t4_reload", 3'b001, 3'b000, 1'b0);
        cycle("t4_clr2", 3'b000, 3'b000, 1'b1);
        cycle("t4_p1b", 3'b001, 3'b000, 1'b0);
        cycle("t4_p2b", 3'b010, 3'b000, 1'b0);
        cycle("t4_early3", 3'b100, 3'b000, 1'b0);
        cycle("t4_clr3", 3'b000, 3'b000, 1'b1);

        // Generator wrap and rank-13 value.
        for (int i = 0; i < 14 && m_gen != 13; i++) cycle("t5_spin", 3'b000, 3'b000, 1'b0);
        cycle("t5_king", 3'b001, 3'b000, 1'b0);
        cycle("t5_wrap", 3'b000, 3'b001, 1'b0);
        cycle("t5_p2", 3'b010, 3'b000, 1'b0);
        cycle("t5_d2", 3'b000, 3'b010, 1'b0);
        cycle("t5_p3", 3'b100, 3'b000, 1'b0);
        cycle("t5_d3", 3'b000, 3'b100, 1'b0);

        // Mid-hand reset, then clear racing a load.
        cycle("t6_clr", 3'b000, 3'b000, 1'b1);
        cycle("t6_p1", 3'b001, 3'b000, 1'b0);
        cycle("t6_d1", 3'b000, 3'b001, 1'b0);
        do_reset("t6_async_rst");
        cycle("t6_p1b", 3'b001, 3'b000, 1'b0);
        cycle("t6_clr_load", 3'b000, 3'b001, 1'b1);
        cycle("t6_after", 3'b000, 3'b000, 1'b0);

        if (exp_q.size() != 0) check_eq("queue_left", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
